vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch, in pixels; H_TOTAL = sum of the four = 800.
REQ-003 Parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33: vertical equivalents, in lines; V_TOTAL = 525.
REQ-004 Parameter CLK_DIV, default 2: system clocks per pixel; legal range 1..16.
REQ-005 clk  input  1  system clock; all logic rises on its posedge.
REQ-006 reset_n  input  1  synchronous active-low reset, sampled on the clk posedge.
REQ-007 x  output  10  current horizontal pixel count, 0..H_TOTAL-1.
REQ-008 y  output  10  current line count, 0..V_TOTAL-1.
REQ-009 pixel_on  output  1  high while x < H_ACTIVE and y < V_ACTIVE.
REQ-010 hsync  output  1  active-low horizontal sync.
REQ-011 vsync  output  1  active-low vertical sync.
REQ-012 pixel_tick  output  1  one-clk pulse on each cycle where the pixel counter advances.
REQ-013 frame_start  output  1  one-clk pulse when the counters wrap to (0,0).

Function
REQ-014 Divider counts 0..CLK_DIV-1 and wraps; pixel_tick is asserted in the cycle the divider wraps; CLK_DIV=1 gives pixel_tick high every cycle.
REQ-015 On pixel_tick, x increments; at x = H_TOTAL-1, x wraps to 0 and y increments.
REQ-016 On pixel_tick with x = H_TOTAL-1 and y = V_TOTAL-1, both x and y wrap to 0 in the same cycle, and frame_start pulses for that one cycle.
REQ-017 hsync is 0 exactly when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults); otherwise 1.
REQ-018 vsync is 0 exactly when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults); otherwise 1.
REQ-019 x, y, pixel_on, hsync and vsync are registered, and all five change in the same clk edge; sync and pixel_on are never one pixel late relative to x/y.
REQ-020 Between pixel_ticks, all outputs except pixel_tick hold their values.
REQ-021 x and y never exceed H_TOTAL-1 and V_TOTAL-1; no intermediate or out-of-range count is ever visible.
REQ-022 The counters run freely; there is no enable or stall input.

Reset
REQ-023 While reset_n = 0 at a clk edge: divider = 0, x = 0, y = 0, pixel_on = 0, hsync = 1, vsync = 1, pixel_tick = 0, frame_start = 0.
REQ-024 On the first clk edge after reset_n returns to 1, pixel_on becomes 1 for position (0,0); the first pixel_tick follows CLK_DIV clks later.
REQ-025 Asserting reset mid-line or mid-frame takes effect at the next edge and overrides any pending tick or wrap.

Structure
REQ-026 The timing parameter defaults, H_TOTAL, V_TOTAL and the sync start/end constants live in a shared package (vga_timing_pkg); the downstream colour stage uses the same package for its band thresholds.
REQ-027 A single sub-module, vga_pixel_div, implements the clock-enable divider; the counters and decode stay in the top module.

Verification
REQ-028 Hold reset_n=0 for 3 clks -> x=0, y=0, pixel_on=0, hsync=1, vsync=1; first edge after release -> pixel_on=1.
REQ-029 CLK_DIV=2, run one line -> pixel_tick every 2nd clk; x steps 0..799 then 0; y goes 0->1; 1600 clks per line.
REQ-030 Line-timing check -> pixel_on falls at x=640; hsync low for exactly 96 pixels, x=656..751.
REQ-031 Run a full frame -> vsync low on y=490,491 only; frame_start pulses once after 800*525*2 = 840000 clks; y never reaches 525.
REQ-032 Assert reset at x=700, y=300 -> next edge x=0, y=0, hsync=1, no frame_start.
REQ-033 CLK_DIV=1 -> pixel_tick constantly high; line period is 800 clks; sync positions unchanged.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and counter widths, used by the sync
// generator and by the downstream colour stage for its band thresholds.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int DIV_W = 4;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  localparam int CLK_DIV_DEF = 2;

  // Half-open window test [lo, hi) on a counter value.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Pixel clock-enable divider: tick is high for one clk every CLK_DIV clks.
// The first clk after reset only arms the divider, so counting starts from (0,0).
module vga_pixel_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             run;
  logic [DIV_W-1:0] div;

  assign tick = run && (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run <= 1'b0;
      div <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counter with registered sync/blanking decode; decode is taken from
// the next counter values so every output changes on the same edge as x/y.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             pixel_on,
  output logic             hsync,
  output logic             vsync,
  output logic             pixel_tick,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             tick;
  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;
  logic             frame_wrap;

  vga_pixel_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_comb begin
    x_next     = x;
    y_next     = y;
    frame_wrap = 1'b0;
    if (tick) begin
      if (x == H_LAST) begin
        x_next = '0;
        if (y == V_LAST) begin
          y_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          y_next = y + 1'b1;
        end
      end else begin
        x_next = x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x           <= '0;
      y           <= '0;
      pixel_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= x_next;
      y           <= y_next;
      pixel_on    <= (x_next < H_VIS) && (y_next < V_VIS);
      hsync       <= !in_window(x_next, HS_START, HS_END);
      vsync       <= !in_window(y_next, VS_START, VS_END);
      pixel_tick  <= tick;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default timing at CLK_DIV 2 and 1,
// and a reduced raster at CLK_DIV 3) compared every clk against an arithmetic raster model.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  logic [9:0] xa, ya, xb, yb, xc, yc;
  logic po_a, hs_a, vs_a, pt_a, fs_a;
  logic po_b, hs_b, vs_b, pt_b, fs_b;
  logic po_c, hs_c, vs_c, pt_c, fs_c;

  vga_sync_gen #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset_n(rst_a), .x(xa), .y(ya), .pixel_on(po_a), .hsync(hs_a),
    .vsync(vs_a), .pixel_tick(pt_a), .frame_start(fs_a));

  vga_sync_gen #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset_n(rst_b), .x(xb), .y(yb), .pixel_on(po_b), .hsync(hs_b),
    .vsync(vs_b), .pixel_tick(pt_b), .frame_start(fs_b));

  vga_sync_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
                 .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(3)) dut_c (
    .clk(clk), .reset_n(rst_c), .x(xc), .y(yc), .pixel_on(po_c), .hsync(hs_c),
    .vsync(vs_c), .pixel_tick(pt_c), .frame_start(fs_c));

  int n_cmp = 0;
  int n_err = 0;
  int n_a = 0, n_b = 0, n_c = 0;   // clk edges since reset release (0 = in reset)
  bit tally = 1'b0;
  int hs_low_a = 0, tick_b = 0, frames_c = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Raster model: pixel index advances once per d clks, starting d clks after release.
  task automatic check_dut(input string name, input int n,
                           input int ha, input int hfp, input int hs, input int hbp,
                           input int va, input int vfp, input int vs, input int vbp,
                           input int d,
                           input logic [9:0] xo, input logic [9:0] yo,
                           input logic po, input logic hso, input logic vso,
                           input logic pto, input logic fso);
    int ht, vt, p, ex, ey;
    logic epo, ehs, evs, ept, efs;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    if (n == 0) begin
      ex = 0; ey = 0; epo = 1'b0; ehs = 1'b1; evs = 1'b1; ept = 1'b0; efs = 1'b0;
    end else begin
      p   = (n - 1) / d;
      ex  = p % ht;
      ey  = (p / ht) % vt;
      epo = (ex < ha) && (ey < va);
      ehs = !((ex >= ha + hfp) && (ex < ha + hfp + hs));
      evs = !((ey >= va + vfp) && (ey < va + vfp + vs));
      ept = (n > 1) && ((n - 1) % d == 0);
      efs = ept && (ex == 0) && (ey == 0);
    end
    cmp({name, ".x"}, 32'(xo), 32'(ex));
    cmp({name, ".y"}, 32'(yo), 32'(ey));
    cmp({name, ".pixel_on"}, 32'(po), 32'(epo));
    cmp({name, ".hsync"}, 32'(hso), 32'(ehs));
    cmp({name, ".vsync"}, 32'(vso), 32'(evs));
    cmp({name, ".pixel_tick"}, 32'(pto), 32'(ept));
    cmp({name, ".frame_start"}, 32'(fso), 32'(efs));
  endtask

  task automatic step();
    @(posedge clk);
    n_a = rst_a ? n_a + 1 : 0;
    n_b = rst_b ? n_b + 1 : 0;
    n_c = rst_c ? n_c + 1 : 0;
    @(negedge clk);
    check_dut("a", n_a, 640, 16, 96, 48, 480, 10, 2, 33, 2, xa, ya, po_a, hs_a, vs_a, pt_a, fs_a);
    check_dut("b", n_b, 640, 16, 96, 48, 480, 10, 2, 33, 1, xb, yb, po_b, hs_b, vs_b, pt_b, fs_b);
    check_dut("c", n_c, 16, 4, 6, 4, 10, 2, 2, 3, 3, xc, yc, po_c, hs_c, vs_c, pt_c, fs_c);
    if (tally) begin
      if (n_a >= 1 && n_a <= 1600 && hs_a === 1'b0) hs_low_a++;
      if (n_b >= 2 && n_b <= 801 && pt_b === 1'b1) tick_b++;
      if (fs_c === 1'b1) frames_c++;
    end
  endtask

  initial begin
    bit hit;
    int cyc, which, hold;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Free run from release: two default lines on a, four on b, two small frames on c.
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tally = 1'b1;
    for (int i = 0; i < 3300; i++) step();
    tally = 1'b0;
    cmp("a.hsync_low_clks_line0", 32'(hs_low_a), 32'd192);
    cmp("b.ticks_per_800_clks", 32'(tick_b), 32'd800);
    cmp("c.frame_starts", 32'(frames_c), 32'd2);

    // Mid-frame reset on c while inside hsync (x=22, y=8).
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (n_c > 0 && ((n_c - 1) / 3) % 30 == 22 && (((n_c - 1) / 3) / 30) % 17 == 8) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    cmp("c.reached_mid_frame", 32'(hit), 32'd1);
    rst_c = 1'b0;
    step();
    cmp("c.reset_x", 32'(xc), 32'd0);
    cmp("c.reset_y", 32'(yc), 32'd0);
    cmp("c.reset_hsync", 32'(hs_c), 32'd1);
    cmp("c.reset_frame_start", 32'(fs_c), 32'd0);
    rst_c = 1'b1;
    step();
    cmp("c.release_pixel_on", 32'(po_c), 32'd1);

    // Random run lengths with random resets on a random instance.
    for (int k = 0; k < 16; k++) begin
      cyc = int'($urandom_range(1, 300));
      for (int i = 0; i < cyc; i++) step();
      which = int'($urandom_range(0, 2));
      hold  = int'($urandom_range(1, 3));
      if (which == 0) rst_a = 1'b0;
      else if (which == 1) rst_b = 1'b0;
      else rst_c = 1'b0;
      for (int i = 0; i < hold; i++) step();
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    end
    for (int i = 0; i < 200; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
